// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: burst FSM states and default timing.
package mem_pkg;
    localparam int DEF_LATENCY   = 4;
    localparam int DEF_BURST_LEN = 8;
    localparam int DW            = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BWAIT   = 2'd1,
        BSTREAM = 2'd2
    } bstate_e;
endpackage

// File: rtl/lat_pipe.sv
// Valid/data delay line: a value entering on edge t leaves the last stage after edge t+DEPTH-1,
// so a register fed from vld_o/dat_o presents it DEPTH edges after entry.
module lat_pipe #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         vld_i,
    input  logic [W-1:0] dat_i,
    output logic         vld_o,
    output logic [W-1:0] dat_o
);
    logic [DEPTH-1:0] vld_q;
    logic [W-1:0]     dat_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) dat_q[i] <= '0;
        end else begin
            vld_q    <= {vld_q[DEPTH-2:0], vld_i};
            dat_q[0] <= dat_i;
            for (int i = 1; i < DEPTH; i++) dat_q[i] <= dat_q[i-1];
        end
    end

    assign vld_o = vld_q[DEPTH-1];
    assign dat_o = dat_q[DEPTH-1];
endmodule

// File: rtl/mem_responder.sv
// Fixed-latency 16-bit memory responder: pipelined single reads, immediate writes and
// aligned block reads streamed by a small FSM that holds off new requests while busy.
module mem_responder
    import mem_pkg::*;
#(
    parameter int LATENCY   = DEF_LATENCY,
    parameter int BURST_LEN = DEF_BURST_LEN,
    parameter int AW        = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          wr,
    input  logic          burst,
    input  logic [15:0]   addr,
    input  logic [DW-1:0] data_in,
    output logic          ready,
    output logic [DW-1:0] data_out,
    output logic          data_valid,
    output logic [2:0]    beat_idx
);
    localparam int BW = $clog2(BURST_LEN);

    logic [DW-1:0] mem [2**AW];

    logic [AW-1:0] waddr;
    logic          unused_addr;
    logic          accept;
    logic          rd_single;
    logic          rd_burst;

    bstate_e          state_q, state_d;
    logic [3:0]       wcnt_q, wcnt_d;
    logic [BW-1:0]    bcnt_q, bcnt_d;
    logic [AW-BW-1:0] blk_q, blk_d;
    logic             beat_go;
    logic [BW-1:0]    beat_sel;

    logic          pipe_vld;
    logic [DW-1:0] pipe_dat;

    logic          data_valid_q, data_valid_d;
    logic [DW-1:0] data_out_q, data_out_d;
    logic [2:0]    beat_idx_q, beat_idx_d;

    assign waddr       = addr[AW:1];
    assign unused_addr = addr[0] ^ (^(addr >> (AW + 1)));
    assign ready       = (state_q == IDLE);
    assign accept      = enable & ready;
    assign rd_single   = accept & ~wr & ~burst;
    assign rd_burst    = accept & ~wr & burst;

    // Storage is deliberately outside the reset domain so contents survive rst.
    always_ff @(posedge clk) begin
        if (accept && wr) mem[waddr] <= data_in;
    end

    lat_pipe #(
        .DEPTH (LATENCY),
        .W     (DW)
    ) u_lat_pipe (
        .clk   (clk),
        .rst   (rst),
        .vld_i (rd_single),
        .dat_i (mem[waddr]),
        .vld_o (pipe_vld),
        .dat_o (pipe_dat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            bcnt_q  <= '0;
            blk_q   <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            bcnt_q  <= bcnt_d;
            blk_q   <= blk_d;
        end
    end

    // Beat 0 is loaded into the output register on the edge that leaves BWAIT, so the
    // beats coincide with BSTREAM and ready rises the cycle after the last beat.
    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        bcnt_d   = bcnt_q;
        blk_d    = blk_q;
        beat_go  = 1'b0;
        beat_sel = bcnt_q;
        case (state_q)
            IDLE: begin
                if (rd_burst) begin
                    state_d = BWAIT;
                    wcnt_d  = '0;
                    blk_d   = waddr[AW-1:BW];
                end
            end
            BWAIT: begin
                if (wcnt_q == 4'(LATENCY - 1)) begin
                    state_d  = BSTREAM;
                    beat_go  = 1'b1;
                    beat_sel = '0;
                    bcnt_d   = '0;
                end else begin
                    wcnt_d = wcnt_q + 4'd1;
                end
            end
            BSTREAM: begin
                if (bcnt_q == BW'(BURST_LEN - 1)) begin
                    state_d = IDLE;
                end else begin
                    beat_go  = 1'b1;
                    beat_sel = bcnt_q + 1'b1;
                    bcnt_d   = bcnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Single reads and burst beats never coincide: singles all precede the burst accept.
    always_comb begin
        data_valid_d = 1'b0;
        data_out_d   = data_out_q;
        beat_idx_d   = beat_idx_q;
        if (pipe_vld) begin
            data_valid_d = 1'b1;
            data_out_d   = pipe_dat;
            beat_idx_d   = '0;
        end else if (beat_go) begin
            data_valid_d = 1'b1;
            data_out_d   = mem[{blk_q, beat_sel}];
            beat_idx_d   = 3'(beat_sel);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_valid_q <= 1'b0;
            data_out_q   <= '0;
            beat_idx_q   <= '0;
        end else begin
            data_valid_q <= data_valid_d;
            data_out_q   <= data_out_d;
            beat_idx_q   <= beat_idx_d;
        end
    end

    assign data_valid = data_valid_q;
    assign data_out   = data_out_q;
    assign beat_idx   = beat_idx_q;
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed scenarios plus a randomized run against a
// transaction-level model (word array + expected-beat list with cycle stamps).
module tb_mem_responder;
    localparam int L  = 4;
    localparam int BL = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        wr;
    logic        burst;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic        ready;
    logic [15:0] data_out;
    logic        data_valid;
    logic [2:0]  beat_idx;

    mem_responder #(
        .LATENCY   (L),
        .BURST_LEN (BL),
        .AW        (15)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .wr         (wr),
        .burst      (burst),
        .addr       (addr),
        .data_in    (data_in),
        .ready      (ready),
        .data_out   (data_out),
        .data_valid (data_valid),
        .beat_idx   (beat_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [15:0] dat;
        logic [2:0]  idx;
    } beat_t;

    beat_t       beats[$];
    beat_t       exp_q[$];
    logic        rdy_log[int];
    logic [15:0] model[int];
    int          cyc_n   = 0;
    int          n_tests = 0;
    int          n_fail  = 0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    always @(negedge clk) begin
        rdy_log[cyc_n] = ready;
        if (data_valid !== 1'b0) beats.push_back('{cyc_n, data_out, beat_idx});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_in();
        enable  = 1'b0;
        wr      = 1'b0;
        burst   = 1'b0;
        addr    = '0;
        data_in = '0;
    endtask

    task automatic do_write(input logic [15:0] a, input logic [15:0] d);
        enable = 1'b1; wr = 1'b1; burst = 1'b0; addr = a; data_in = d;
        step();
        clear_in();
        model[int'(a[15:1])] = d;
    endtask

    task automatic do_read(input logic [15:0] a, input logic b, output int acc);
        enable = 1'b1; wr = 1'b0; burst = b; addr = a;
        step();
        acc = cyc_n;
        clear_in();
    endtask

    function automatic void expect_single(input int acc, input logic [15:0] a);
        exp_q.push_back('{acc + L, model[int'(a[15:1])], 3'd0});
    endfunction

    function automatic void expect_burst(input int acc, input logic [15:0] a);
        int base;
        base = int'(a[15:1]) & ~(BL - 1);
        for (int i = 0; i < BL; i++) exp_q.push_back('{acc + L + i, model[base + i], 3'(i)});
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        clear_in();
        steps(3);
        n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ready); end
        n_tests++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", data_valid); end
        n_tests++; if (data_out !== 16'h0000) begin n_fail++; $display("FAIL reset_data: got %h want 0000", data_out); end
        n_tests++; if (beat_idx !== 3'd0) begin n_fail++; $display("FAIL reset_idx: got %0d want 0", beat_idx); end
        rst = 1'b0;
        step();
        n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got %b want 1", ready); end
    endtask

    task automatic test_write_read();
        int acc;
        beats.delete();
        do_write(16'h0010, 16'h1234);
        do_read(16'h0010, 1'b0, acc);
        steps(L + 3);
        n_tests++; if (beats.size() != 1) begin n_fail++; $display("FAIL wr_rd_count: got %0d want 1", beats.size()); end
        if (beats.size() >= 1) begin
            n_tests++; if (beats[0].cyc != acc + L) begin n_fail++; $display("FAIL wr_rd_latency: got %0d want %0d", beats[0].cyc - acc, L); end
            n_tests++; if (beats[0].dat !== 16'h1234) begin n_fail++; $display("FAIL wr_rd_data: got %h want 1234", beats[0].dat); end
            n_tests++; if (beats[0].idx !== 3'd0) begin n_fail++; $display("FAIL wr_rd_idx: got %0d want 0", beats[0].idx); end
        end
        n_tests++; if (data_valid !== 1'b0 || data_out !== 16'h1234) begin
            n_fail++; $display("FAIL hold_data: got vld=%b dat=%h want vld=0 dat=1234", data_valid, data_out);
        end
    endtask

    task automatic test_back_to_back();
        int acc0, acc1, acc2;
        do_write(16'h0000, 16'h000A);
        do_write(16'h0002, 16'h000B);
        do_write(16'h0004, 16'h000C);
        beats.delete();
        do_read(16'h0000, 1'b0, acc0);
        do_read(16'h0002, 1'b0, acc1);
        do_read(16'h0004, 1'b0, acc2);
        steps(L + 2);
        n_tests++; if (beats.size() != 3) begin n_fail++; $display("FAIL b2b_count: got %0d want 3", beats.size()); end
        for (int i = 0; i < 3 && i < beats.size(); i++) begin
            n_tests++;
            if (beats[i].cyc != acc0 + L + i || beats[i].dat !== 16'(16'hA + i) || beats[i].idx !== 3'd0) begin
                n_fail++;
                $display("FAIL b2b_beat%0d: got cyc=+%0d dat=%h idx=%0d want cyc=+%0d dat=%h idx=0",
                         i, beats[i].cyc - acc0, beats[i].dat, beats[i].idx, L + i, 16'hA + i);
            end
        end
    endtask

    task automatic test_burst();
        int acc;
        for (int i = 0; i < BL; i++) do_write(16'(16'h0020 + 2 * i), 16'(i));
        beats.delete();
        do_read(16'h0026, 1'b1, acc);
        n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL burst_ready_low: got %b want 0", ready); end
        steps(L + BL + 2);
        n_tests++; if (beats.size() != BL) begin n_fail++; $display("FAIL burst_count: got %0d want %0d", beats.size(), BL); end
        for (int i = 0; i < BL && i < beats.size(); i++) begin
            n_tests++;
            if (beats[i].cyc != acc + L + i || beats[i].dat !== 16'(i) || beats[i].idx !== 3'(i)) begin
                n_fail++;
                $display("FAIL burst_beat%0d: got cyc=+%0d dat=%h idx=%0d want cyc=+%0d dat=%h idx=%0d",
                         i, beats[i].cyc - acc, beats[i].dat, beats[i].idx, L + i, i, i);
            end
        end
        n_tests++; if (rdy_log[acc + L + BL - 1] !== 1'b0) begin n_fail++; $display("FAIL burst_ready_last_beat: got %b want 0", rdy_log[acc + L + BL - 1]); end
        n_tests++; if (rdy_log[acc + L + BL] !== 1'b1) begin n_fail++; $display("FAIL burst_ready_after: got %b want 1", rdy_log[acc + L + BL]); end
    endtask

    task automatic test_ignore_busy();
        int acc, acc2;
        do_write(16'h0040, 16'h5555);
        beats.delete();
        do_read(16'h0020, 1'b1, acc);
        enable = 1'b1; wr = 1'b1; burst = 1'b0; addr = 16'h0040; data_in = 16'hDEAD;
        steps(4);
        wr = 1'b0;
        steps(L);
        clear_in();
        steps(4);
        n_tests++; if (beats.size() != BL) begin n_fail++; $display("FAIL busy_beat_count: got %0d want %0d", beats.size(), BL); end
        beats.delete();
        do_read(16'h0040, 1'b0, acc2);
        steps(L + 1);
        n_tests++;
        if (beats.size() != 1 || beats[0].dat !== 16'h5555) begin
            n_fail++;
            $display("FAIL busy_write_ignored: got n=%0d dat=%h want n=1 dat=5555",
                     beats.size(), (beats.size() > 0) ? beats[0].dat : 16'hxxxx);
        end
    endtask

    task automatic test_reset_mid_burst();
        int acc, acc2;
        do_write(16'h0030, 16'h7777);
        beats.delete();
        do_read(16'h0020, 1'b1, acc);
        steps(2);
        rst = 1'b1;
        #1;
        n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready: got %b want 1", ready); end
        n_tests++; if (data_valid !== 1'b0 || data_out !== 16'h0000) begin
            n_fail++; $display("FAIL rst_mid_out: got vld=%b dat=%h want vld=0 dat=0000", data_valid, data_out);
        end
        step();
        rst = 1'b0;
        steps(L + BL + 3);
        n_tests++; if (beats.size() != 0) begin n_fail++; $display("FAIL rst_mid_beats: got %0d want 0", beats.size()); end
        n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready_after: got %b want 1", ready); end
        do_read(16'h0030, 1'b0, acc2);
        do_read(16'h0022, 1'b0, acc);
        steps(L + 2);
        n_tests++;
        if (beats.size() != 2 || beats[0].dat !== 16'h7777 || beats[1].dat !== 16'h0001) begin
            n_fail++;
            $display("FAIL rst_storage_kept: got n=%0d d0=%h d1=%h want n=2 d0=7777 d1=0001", beats.size(),
                     (beats.size() > 0) ? beats[0].dat : 16'hxxxx, (beats.size() > 1) ? beats[1].dat : 16'hxxxx);
        end
    endtask

    task automatic test_single_before_burst();
        int a0, a1;
        beats.delete();
        do_read(16'h0004, 1'b0, a0);
        do_read(16'h0020, 1'b1, a1);
        steps(L + BL + 3);
        n_tests++; if (beats.size() != BL + 1) begin n_fail++; $display("FAIL mix_count: got %0d want %0d", beats.size(), BL + 1); end
        if (beats.size() >= 1) begin
            n_tests++;
            if (beats[0].cyc != a0 + L || beats[0].dat !== 16'h000C || beats[0].idx !== 3'd0) begin
                n_fail++; $display("FAIL mix_single: got cyc=+%0d dat=%h idx=%0d want cyc=+%0d dat=000c idx=0",
                                   beats[0].cyc - a0, beats[0].dat, beats[0].idx, L);
            end
        end
        for (int i = 1; i <= BL && i < beats.size(); i++) begin
            n_tests++;
            if (beats[i].cyc != a0 + L + i || beats[i].dat !== 16'(i - 1) || beats[i].idx !== 3'(i - 1)) begin
                n_fail++; $display("FAIL mix_burst%0d: got cyc=+%0d dat=%h idx=%0d want cyc=+%0d dat=%h idx=%0d",
                                   i - 1, beats[i].cyc - a0, beats[i].dat, beats[i].idx, L + i, i - 1, i - 1);
            end
        end
    endtask

    task automatic test_random();
        int          busy_until, c, op, acc;
        logic        mr;
        logic [15:0] a, d;
        for (int w = 0; w < 64; w++) do_write(16'(16'h0800 + 2 * w), 16'($urandom));
        beats.delete();
        exp_q.delete();
        busy_until = 0;
        for (int n = 0; n < 300; n++) begin
            c  = cyc_n;
            mr = (c >= busy_until);
            n_tests++; if (ready !== mr) begin n_fail++; $display("FAIL rand_ready@%0d: got %b want %b", c, ready, mr); end
            op = $urandom_range(0, 5);
            a  = 16'(16'h0800 + 2 * $urandom_range(0, 63) + $urandom_range(0, 1));
            d  = 16'($urandom);
            enable = (op >= 2); wr = (op == 2); burst = (op == 2) ? 1'($urandom_range(0, 1)) : (op == 5);
            addr = a; data_in = d;
            step();
            acc = cyc_n;
            if (op >= 2 && mr) begin
                if (op == 2) model[int'(a[15:1])] = d;
                else if (op == 5) begin expect_burst(acc, a); busy_until = acc + L + BL; end
                else expect_single(acc, a);
            end
            clear_in();
        end
        steps(L + BL + 2);
        n_tests++; if (beats.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_count: got %0d want %0d", beats.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < beats.size(); i++) begin
            n_tests++;
            if (beats[i].cyc != exp_q[i].cyc || beats[i].dat !== exp_q[i].dat || beats[i].idx !== exp_q[i].idx) begin
                n_fail++;
                $display("FAIL rand_beat%0d: got cyc=%0d dat=%h idx=%0d want cyc=%0d dat=%h idx=%0d", i,
                         beats[i].cyc, beats[i].dat, beats[i].idx, exp_q[i].cyc, exp_q[i].dat, exp_q[i].idx);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        clear_in();
        test_reset();
        test_write_read();
        test_back_to_back();
        test_burst();
        test_ignore_busy();
        test_reset_mid_burst();
        test_single_before_burst();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
